// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op selects, FSM states, shift step helper.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int min_step(input int remaining, input int step);
        return (remaining < step) ? remaining : step;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-step shifter; amount is at most SHIFT_STEP in the iterative path.
module alu_shift_step #(
    parameter int XLEN = 32,
    parameter int SW   = 5
) (
    input  logic [XLEN-1:0] data,
    input  logic            dir_left,
    input  logic            arith,
    input  logic [SW-1:0]   amount,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = data >> amount;
        if (dir_left)
            result = data << amount;
        else if (arith)
            result = XLEN'($signed(data) >>> amount);
    end

endmodule

// File: rtl/alu_iter.sv
// RV32I-style ALU with valid/ready handshake; shifts iterate SHIFT_STEP bits per cycle.
// Build option: ALU_BARREL_SHIFT_EN replaces the iterative shifter with a single-cycle barrel shift.
//
// state    | meaning
// ST_IDLE  | ready for a request, in_ready high
// ST_SHIFT | working register shifting, remaining counts down to zero
// ST_DONE  | result held on out_data until out_ready
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int SHIFT_STEP = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              funct3,
    input  logic                    alt,
    input  logic                    is_reg,
    input  logic [XLEN-1:0]         in1,
    input  logic [XLEN-1:0]         in2,
    input  logic [$clog2(XLEN)-1:0] shamt,
    output logic                    out_valid,
    output logic [XLEN-1:0]         out_data,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int SW = $clog2(XLEN);

    state_t          state;
    logic [XLEN-1:0] work;
    logic [SW-1:0]   remaining;
    logic            dir_left;
    logic            arith;
    logic [SW-1:0]   step_amt;
    logic [XLEN-1:0] step_res;
    logic [XLEN-1:0] comb_res;
    logic            start_shift;

    assign step_amt = SW'(min_step(int'(remaining), SHIFT_STEP));

`ifdef ALU_BARREL_SHIFT_EN
    assign start_shift = 1'b0;
`else
    logic is_shift;
    assign is_shift    = (funct3 == ALU_SLL) || (funct3 == ALU_SR);
    assign start_shift = is_shift && (shamt != '0);
`endif

    alu_shift_step #(.XLEN(XLEN), .SW(SW)) u_shift_step (
        .data     (work),
        .dir_left (dir_left),
        .arith    (arith),
        .amount   (step_amt),
        .result   (step_res)
    );

    always_comb begin
        comb_res = '0;
        case (funct3)
            ALU_ADD:  comb_res = (alt && is_reg) ? (in1 - in2) : (in1 + in2);
            ALU_SLT:  comb_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_SLTU: comb_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
            ALU_XOR:  comb_res = in1 ^ in2;
            ALU_OR:   comb_res = in1 | in2;
            ALU_AND:  comb_res = in1 & in2;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  comb_res = in1 << shamt;
            ALU_SR:   comb_res = alt ? XLEN'($signed(in1) >>> shamt) : (in1 >> shamt);
`else
            // Only reached with shamt == 0; nonzero shifts go through ST_SHIFT.
            ALU_SLL:  comb_res = in1;
            ALU_SR:   comb_res = in1;
`endif
            default:  comb_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            work      <= '0;
            remaining <= '0;
            dir_left  <= 1'b0;
            arith     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (start_shift) begin
                            work      <= in1;
                            remaining <= shamt;
                            dir_left  <= (funct3 == ALU_SLL);
                            arith     <= alt;
                            state     <= ST_SHIFT;
                        end else begin
                            out_data  <= comb_res;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work      <= step_res;
                    remaining <= remaining - step_amt;
                    if (remaining == step_amt) begin
                        out_data  <= step_res;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: two instances (SHIFT_STEP 1 and 4) run every op in lockstep against a reference model.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [2:0]  funct3;
    logic        alt;
    logic        is_reg;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic        out_ready;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] out_data1;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] out_data4;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_res;
    int          exp_lat1;
    int          exp_lat4;

    always #5 clk = ~clk;

    alu_iter #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready1),
        .funct3(funct3), .alt(alt), .is_reg(is_reg), .in1(in1), .in2(in2), .shamt(shamt),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .busy(busy1)
    );

    alu_iter #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready4),
        .funct3(funct3), .alt(alt), .is_reg(is_reg), .in1(in1), .in2(in2), .shamt(shamt),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic a_alt, input logic a_reg,
                                          input logic [31:0] a, input logic [31:0] b, input int sh);
        longint x, d, q;
        d = longint'(1) << sh;
        case (f3)
            3'd0: return (a_alt && a_reg) ? a - b : a + b;
            3'd1: return 32'(longint'(a) * d);
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (!a_alt) return 32'(longint'(a) / d);
                x = longint'(int'(a));
                q = (x >= 0) ? x / d : -((-x + d - 1) / d);
                return 32'(q);
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input int sh, input int step);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if ((f3 == 3'd1 || f3 == 3'd5) && sh != 0) return (sh + step - 1) / step + 1;
        return 1;
`endif
    endfunction

    task automatic drive_req(input logic [2:0] f3, input logic a_alt, input logic a_reg,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        funct3 = f3; alt = a_alt; is_reg = a_reg; in1 = a; in2 = b; shamt = sh;
        in_valid = 1'b1;
        exp_res  = model(f3, a_alt, a_reg, a, b, int'(sh));
        exp_lat1 = latency(f3, int'(sh), 1);
        exp_lat4 = latency(f3, int'(sh), 4);
    endtask

    task automatic accept_and_check();
        int lat1, lat4;
        logic [31:0] d1v, d4v;
        lat1 = 0; lat4 = 0; d1v = '0; d4v = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3 = 3'($urandom); alt = 1'($urandom); is_reg = 1'($urandom);
        in1 = $urandom; in2 = $urandom; shamt = 5'($urandom);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (out_valid1 && lat1 == 0) begin lat1 = cyc; d1v = out_data1; end
            if (out_valid4 && lat4 == 0) begin lat4 = cyc; d4v = out_data4; end
            if (lat1 == 0) check("busy1_while_running", 32'(busy1), 32'd1);
            if (lat1 != 0 && lat4 != 0) break;
            @(posedge clk); #1;
        end
        check("latency_step1", 32'(lat1), 32'(exp_lat1));
        check("latency_step4", 32'(lat4), 32'(exp_lat4));
        check("result_step1", d1v, exp_res);
        check("result_step4", d4v, exp_res);
        check("held_step1", out_data1, exp_res);
`ifdef BENCH
        $display("op done: result %08h step1 lat %0d step4 lat %0d", d1v, lat1, lat4);
`endif
    endtask

    task automatic release_out(input int hold, input logic [31:0] held);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("stall_valid1", 32'(out_valid1), 32'd1);
            check("stall_data4", out_data4, held);
            check("stall_data1", out_data1, held);
            check("stall_in_ready4", 32'(in_ready4), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid1", 32'(out_valid1), 32'd0);
        check("drop_valid4", 32'(out_valid4), 32'd0);
        check("ready_again1", 32'(in_ready1), 32'd1);
        check("ready_again4", 32'(in_ready4), 32'd1);
    endtask

    initial begin
        logic [31:0] saved;
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        funct3 = '0; alt = 1'b0; is_reg = 1'b0; in1 = '0; in2 = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid1), 32'd0);
        check("reset_out_data", out_data1, 32'd0);
        check("reset_busy", 32'(busy4), 32'd0);
        check("reset_in_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        drive_req(3'd0, 1'b1, 1'b1, 32'd5, 32'd3, 5'd0);          accept_and_check(); release_out(0, exp_res);
        drive_req(3'd0, 1'b1, 1'b0, 32'd5, 32'd3, 5'd0);          accept_and_check(); release_out(0, exp_res);
        drive_req(3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 5'd5);  accept_and_check(); release_out(0, exp_res);
        drive_req(3'd1, 1'b0, 1'b1, 32'd1, 32'd0, 5'd31);         accept_and_check(); release_out(0, exp_res);
        drive_req(3'd1, 1'b0, 1'b1, 32'h1234_5678, 32'd0, 5'd0);  accept_and_check(); release_out(0, exp_res);
        drive_req(3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0);  accept_and_check(); release_out(0, exp_res);
        drive_req(3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0);  accept_and_check(); release_out(0, exp_res);
        drive_req(3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 5'd0);  accept_and_check(); release_out(0, exp_res);

        // Backpressure with a second request already waiting.
        drive_req(3'd4, 1'b0, 1'b1, 32'hA5A5_0F0F, 32'h0FF0_FF00, 5'd0);
        accept_and_check();
        saved = exp_res;
        drive_req(3'd5, 1'b0, 1'b1, 32'hF000_0001, 32'd0, 5'd7);
        release_out(4, saved);
        accept_and_check();
        release_out(0, exp_res);

        // Reset in the middle of a long shift.
        drive_req(3'd1, 1'b0, 1'b1, 32'h0000_0003, 32'd0, 5'd20);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid1", 32'(out_valid1), 32'd0);
        check("abort_out_data4", out_data4, 32'd0);
        check("abort_busy1", 32'(busy1), 32'd0);
        check("abort_in_ready4", 32'(in_ready4), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        drive_req(3'd7, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h00FF_FF00, 5'd0);
        accept_and_check(); release_out(0, exp_res);

        for (int n = 0; n < 40; n++) begin
            drive_req(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                      $urandom, $urandom, 5'($urandom));
            accept_and_check();
            release_out($urandom_range(0, 2), exp_res);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
Parametrised RV32I-style ALU for the multi-cycle core, generalised to XLEN bits with a valid/ready handshake on both sides.
- Non-shift ops complete in one cycle.
- Shifts (SLL/SRL/SRA) run iteratively at SHIFT_STEP bits per cycle to save LUTs on the ULX3S target.
- Sits between the register-fetch stage and write-back; the core's EXECUTE state waits on out_valid.

Parameters:
XLEN, 32, datapath width in bits (power of 2, 8..64)
SHIFT_STEP, 1, bits shifted per iterative cycle (power of 2, 1..XLEN/2)

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
funct3  input  3  RISC-V funct3 op select
alt  input  1  funct7[5]: SUB / SRA select
is_reg  input  1  instr[5]: 1 = register-register form
in1  input  XLEN  rs1 operand
in2  input  XLEN  rs2 value or immediate
shamt  input  $clog2(XLEN)  shift amount
out_valid  output  1  result available
out_data  output  XLEN  result
out_ready  input  1  consumer takes result
busy  output  1  state != IDLE

Behaviour:
- One clock. Reset is synchronous and active-low: resetn sampled on rising clk; low -> state IDLE, out_valid=0, out_data=0, busy=0, in_ready=1.
- Reset mid-operation aborts the operation and discards its result.
- States:
  - IDLE: in_ready=1. On in_valid: capture operands and op. Shift op with shamt!=0 -> SHIFT; else compute result -> DONE.
  - SHIFT: each cycle shift the working register by min(remaining, SHIFT_STEP), then remaining -= that amount. When remaining reaches 0 -> DONE.
  - DONE: out_valid=1, out_data stable. On out_ready -> IDLE. No new request is accepted in this state.
- Latency (in_valid&in_ready to out_valid):
  - Non-shift, and shifts with shamt=0: 1 cycle.
  - Other shifts: ceil(shamt/SHIFT_STEP)+1 cycles.
- Op decode, by funct3:
  - 000: SUB if alt&is_reg, else ADD.
  - 001: SLL.
  - 010: SLT, signed.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRA if alt, else SRL.
  - 110: OR.
  - 111: AND.
- Width and arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU return a zero-extended 0 or 1.
  - SRA replicates the captured in1 MSB on every step.
- Operand capture: inputs are sampled only on handshake. Input changes afterwards are ignored.
- in_ready = (state==IDLE). Requests while busy are not accepted; the driver must hold in_valid.
- out_valid deasserted in the cycle after out_ready is sampled high.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, every op has 1-cycle latency, and SHIFT is never entered (SHIFT_STEP ignored).
- Undefined: iterative shifter as above.
- BENCH builds additionally $display each completed op.

Decomposition:
- Shared package alu_pkg:
  - funct3 localparams (ALU_ADD..ALU_AND).
  - State encoding (IDLE/SHIFT/DONE).
  - XLEN default.
  - Helper function for min(remaining, SHIFT_STEP).
- Sub-module alu_shift_step: combinational one-step shifter (dir, arith, amount <= SHIFT_STEP) instantiated in the SHIFT datapath.
- Comb ops stay inline in alu_iter.

Test Plan:
- ADD/SUB: in1=5, in2=3, alt=1, is_reg=1 -> 2 after 1 cycle. Same with is_reg=0 (ADDI) -> 8.
- SRA XLEN=32, STEP=1: in1=0x8000_0000, shamt=5, alt=1 -> 0xFC00_0000, out_valid 6 cycles after handshake, busy high throughout.
- SLL STEP=4: in1=1, shamt=31 -> 0x8000_0000 after ceil(31/4)+1=9 cycles; shamt=0 -> in1 unchanged after 1 cycle.
- SLT vs SLTU: in1=0xFFFF_FFFF, in2=1 -> SLT=1, SLTU=0.
- Backpressure: out_ready held low 4 cycles -> out_valid/out_data stable, in_ready=0, second in_valid not accepted until after out_ready.
- Reset: resetn low during SHIFT (shamt=20) -> next cycle IDLE, out_valid=0, out_data=0. A following op completes correctly.
